// File: rtl/pic_pkg.sv
// Shared definitions for the PIC blocks: OCW2 command encodings (R,SL,EOI)
// and the level-index width helper.
package pic_pkg;

  localparam logic [2:0] CMD_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] CMD_NS_EOI       = 3'b001;
  localparam logic [2:0] CMD_NOP          = 3'b010;
  localparam logic [2:0] CMD_S_EOI        = 3'b011;
  localparam logic [2:0] CMD_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] CMD_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] CMD_SET_PRIO     = 3'b110;
  localparam logic [2:0] CMD_ROT_S_EOI    = 3'b111;

  // Width of an index into n levels; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pic_rot_prio_enc.sv
// Rotating priority encoder: picks the first set request bit starting at
// (lowest_prio+1) mod NUM_IRQ and walking upward with wrap.
module pic_rot_prio_enc
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = idx_w(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [IDX_W-1:0]   lowest_prio,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int pos;

  // Scan from the lowest priority back to the highest so the final hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      pos = int'(lowest_prio) + 1 + k;
      if (pos >= NUM_IRQ) pos = pos - NUM_IRQ;
      if (pos >= NUM_IRQ) pos = pos - NUM_IRQ;
      if (req[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pic_isr_bank.sv
// In-service register bank: acknowledge sets a level, OCW2 EOI clears it,
// and a rotating lowest-priority pointer orders the levels.
module pic_isr_bank
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = idx_w(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init_clear,
  input  logic               aeoi_mode,
  input  logic               ack_valid,
  input  logic [IDX_W-1:0]   ack_idx,
  input  logic               ocw2_valid,
  input  logic [2:0]         ocw2_cmd,
  input  logic [IDX_W-1:0]   ocw2_level,
  input  logic               smm,
  input  logic [NUM_IRQ-1:0] imr,
  output logic [NUM_IRQ-1:0] isr_out,
  output logic               top_valid,
  output logic [IDX_W-1:0]   top_idx,
  output logic [IDX_W-1:0]   lowest_prio,
  output logic               eoi_err
);

  localparam logic [IDX_W-1:0]   PRIO_RST = IDX_W'(NUM_IRQ - 1);
  localparam logic [NUM_IRQ-1:0] ONE_HOT0 = NUM_IRQ'(1);

  logic               rotate_in_aeoi;
  logic [NUM_IRQ-1:0] eligible;
  logic               ack_ok;
  logic               lvl_ok;
  logic [NUM_IRQ-1:0] clear_mask;
  logic [NUM_IRQ-1:0] set_mask;
  logic               ocw_prio_upd;
  logic [IDX_W-1:0]   prio_next;
  logic               rot_next;
  logic               err_next;

  // Special mask mode hides masked in-service levels from selection only.
  assign eligible = isr_out & ~(smm ? imr : '0);

  pic_rot_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_enc (
    .req         (eligible),
    .lowest_prio (lowest_prio),
    .valid       (top_valid),
    .idx         (top_idx)
  );

  assign ack_ok = ack_valid && (int'(ack_idx) < NUM_IRQ);
  assign lvl_ok = int'(ocw2_level) < NUM_IRQ;

  // ack_valid and ocw2_valid are single-cycle pulses with no backpressure;
  // both are evaluated against the current state and merged into one update.
  always_comb begin
    clear_mask   = '0;
    set_mask     = '0;
    ocw_prio_upd = 1'b0;
    prio_next    = lowest_prio;
    rot_next     = rotate_in_aeoi;
    err_next     = 1'b0;

    if (ocw2_valid) begin
      case (ocw2_cmd)
        CMD_NS_EOI: begin
          if (top_valid) clear_mask = ONE_HOT0 << top_idx;
          else           err_next   = 1'b1;
        end
        CMD_S_EOI: begin
          if (lvl_ok) clear_mask = ONE_HOT0 << ocw2_level;
        end
        CMD_ROT_NS_EOI: begin
          if (top_valid) begin
            clear_mask   = ONE_HOT0 << top_idx;
            prio_next    = top_idx;
            ocw_prio_upd = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        CMD_ROT_S_EOI: begin
          if (lvl_ok) begin
            clear_mask   = ONE_HOT0 << ocw2_level;
            prio_next    = ocw2_level;
            ocw_prio_upd = 1'b1;
          end
        end
        CMD_SET_PRIO: begin
          if (lvl_ok) begin
            prio_next    = ocw2_level;
            ocw_prio_upd = 1'b1;
          end
        end
        CMD_ROT_AEOI_SET: rot_next = 1'b1;
        CMD_ROT_AEOI_CLR: rot_next = 1'b0;
        default: ;
      endcase
    end

    // In AEOI the level completes with the acknowledge, so it never lands in the ISR.
    if (ack_ok) begin
      if (!aeoi_mode)                                      set_mask  = ONE_HOT0 << ack_idx;
      else if (rotate_in_aeoi && !ocw_prio_upd)            prio_next = ack_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || init_clear) begin
      isr_out        <= '0;
      lowest_prio    <= PRIO_RST;
      rotate_in_aeoi <= 1'b0;
      eoi_err        <= 1'b0;
    end else begin
      isr_out        <= (isr_out & ~clear_mask) | set_mask;
      lowest_prio    <= prio_next;
      rotate_in_aeoi <= rot_next;
      eoi_err        <= err_next;
    end
  end

endmodule

// File: tb/tb_pic_isr_bank.sv
// Directed bench for pic_isr_bank: an 8-level instance for the main scenarios
// and a 6-level instance for out-of-range indices and wrap.
module tb_pic_isr_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // 8-level instance
  logic       a_init_clear, a_aeoi_mode, a_ack_valid, a_ocw2_valid, a_smm;
  logic [2:0] a_ack_idx, a_ocw2_cmd, a_ocw2_level;
  logic [7:0] a_imr, a_isr_out;
  logic       a_top_valid, a_eoi_err;
  logic [2:0] a_top_idx, a_lowest_prio;

  // 6-level instance
  logic       b_init_clear, b_aeoi_mode, b_ack_valid, b_ocw2_valid, b_smm;
  logic [2:0] b_ack_idx, b_ocw2_cmd, b_ocw2_level;
  logic [5:0] b_imr, b_isr_out;
  logic       b_top_valid, b_eoi_err;
  logic [2:0] b_top_idx, b_lowest_prio;

  pic_isr_bank #(.NUM_IRQ(8)) dut8 (
    .clk(clk), .reset(reset), .init_clear(a_init_clear), .aeoi_mode(a_aeoi_mode),
    .ack_valid(a_ack_valid), .ack_idx(a_ack_idx), .ocw2_valid(a_ocw2_valid),
    .ocw2_cmd(a_ocw2_cmd), .ocw2_level(a_ocw2_level), .smm(a_smm), .imr(a_imr),
    .isr_out(a_isr_out), .top_valid(a_top_valid), .top_idx(a_top_idx),
    .lowest_prio(a_lowest_prio), .eoi_err(a_eoi_err)
  );

  pic_isr_bank #(.NUM_IRQ(6)) dut6 (
    .clk(clk), .reset(reset), .init_clear(b_init_clear), .aeoi_mode(b_aeoi_mode),
    .ack_valid(b_ack_valid), .ack_idx(b_ack_idx), .ocw2_valid(b_ocw2_valid),
    .ocw2_cmd(b_ocw2_cmd), .ocw2_level(b_ocw2_level), .smm(b_smm), .imr(b_imr),
    .isr_out(b_isr_out), .top_valid(b_top_valid), .top_idx(b_top_idx),
    .lowest_prio(b_lowest_prio), .eoi_err(b_eoi_err)
  );

  // Drivers: called 1 time unit after a rising edge; return 1 unit after the
  // edge that consumed the pulse, so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack8(input logic [2:0] i);
    a_ack_idx = i; a_ack_valid = 1'b1;
    step();
    a_ack_valid = 1'b0;
  endtask

  task automatic ocw8(input logic [2:0] cmd, input logic [2:0] lvl);
    a_ocw2_cmd = cmd; a_ocw2_level = lvl; a_ocw2_valid = 1'b1;
    step();
    a_ocw2_valid = 1'b0;
  endtask

  task automatic both8(input logic [2:0] i, input logic [2:0] cmd, input logic [2:0] lvl);
    a_ack_idx = i; a_ack_valid = 1'b1;
    a_ocw2_cmd = cmd; a_ocw2_level = lvl; a_ocw2_valid = 1'b1;
    step();
    a_ack_valid = 1'b0; a_ocw2_valid = 1'b0;
  endtask

  task automatic init8();
    a_init_clear = 1'b1;
    step();
    a_init_clear = 1'b0;
  endtask

  task automatic ack6(input logic [2:0] i);
    b_ack_idx = i; b_ack_valid = 1'b1;
    step();
    b_ack_valid = 1'b0;
  endtask

  task automatic ocw6(input logic [2:0] cmd, input logic [2:0] lvl);
    b_ocw2_cmd = cmd; b_ocw2_level = lvl; b_ocw2_valid = 1'b1;
    step();
    b_ocw2_valid = 1'b0;
  endtask

  task automatic test_reset();
    vec_cnt++; if (a_isr_out !== 8'h00) begin err_cnt++; $display("FAIL reset_isr got=%h exp=00", a_isr_out); end
    vec_cnt++; if (a_lowest_prio !== 3'd7) begin err_cnt++; $display("FAIL reset_prio got=%0d exp=7", a_lowest_prio); end
    vec_cnt++; if (a_eoi_err !== 1'b0) begin err_cnt++; $display("FAIL reset_err got=%b exp=0", a_eoi_err); end
    vec_cnt++; if ({a_top_valid, a_top_idx} !== 4'b0_000) begin err_cnt++; $display("FAIL reset_top got=%b/%0d exp=0/0", a_top_valid, a_top_idx); end
    vec_cnt++; if (b_lowest_prio !== 3'd5) begin err_cnt++; $display("FAIL reset_prio6 got=%0d exp=5", b_lowest_prio); end
  endtask

  task automatic test_ns_eoi();
    ack8(3'd3);
    ack8(3'd1);
    vec_cnt++; if (a_isr_out !== 8'h0A) begin err_cnt++; $display("FAIL ack_isr got=%h exp=0a", a_isr_out); end
    vec_cnt++; if (a_top_idx !== 3'd1) begin err_cnt++; $display("FAIL ack_top got=%0d exp=1", a_top_idx); end
    ocw8(3'b001, 3'd0);
    vec_cnt++; if (a_isr_out !== 8'h08) begin err_cnt++; $display("FAIL ns_eoi_isr got=%h exp=08", a_isr_out); end
    vec_cnt++; if (a_top_idx !== 3'd3) begin err_cnt++; $display("FAIL ns_eoi_top got=%0d exp=3", a_top_idx); end
  endtask

  task automatic test_rotate();
    init8();
    vec_cnt++; if (a_isr_out !== 8'h00) begin err_cnt++; $display("FAIL init_clear_isr got=%h exp=00", a_isr_out); end
    ocw8(3'b110, 3'd4);
    vec_cnt++; if (a_lowest_prio !== 3'd4) begin err_cnt++; $display("FAIL set_prio got=%0d exp=4", a_lowest_prio); end
    ack8(3'd2);
    ack8(3'd6);
    vec_cnt++; if (a_top_idx !== 3'd6) begin err_cnt++; $display("FAIL rot_top_pre got=%0d exp=6", a_top_idx); end
    ocw8(3'b101, 3'd0);
    vec_cnt++; if (a_isr_out !== 8'h04) begin err_cnt++; $display("FAIL rot_ns_isr got=%h exp=04", a_isr_out); end
    vec_cnt++; if (a_lowest_prio !== 3'd6) begin err_cnt++; $display("FAIL rot_ns_prio got=%0d exp=6", a_lowest_prio); end
    vec_cnt++; if (a_top_idx !== 3'd2) begin err_cnt++; $display("FAIL rot_ns_top got=%0d exp=2", a_top_idx); end
    ocw8(3'b111, 3'd2);
    vec_cnt++; if ({a_isr_out, a_lowest_prio} !== {8'h00, 3'd2}) begin err_cnt++; $display("FAIL rot_s_eoi got=%h/%0d exp=00/2", a_isr_out, a_lowest_prio); end
  endtask

  task automatic test_aeoi();
    init8();
    a_aeoi_mode = 1'b1;
    ocw8(3'b100, 3'd0);
    ack8(3'd5);
    vec_cnt++; if (a_isr_out !== 8'h00) begin err_cnt++; $display("FAIL aeoi_isr got=%h exp=00", a_isr_out); end
    vec_cnt++; if (a_lowest_prio !== 3'd5) begin err_cnt++; $display("FAIL aeoi_rot_prio got=%0d exp=5", a_lowest_prio); end
    ocw8(3'b000, 3'd0);
    ack8(3'd2);
    vec_cnt++; if (a_lowest_prio !== 3'd5) begin err_cnt++; $display("FAIL aeoi_norot_prio got=%0d exp=5", a_lowest_prio); end
    vec_cnt++; if (a_isr_out !== 8'h00) begin err_cnt++; $display("FAIL aeoi_norot_isr got=%h exp=00", a_isr_out); end
    // Rotation in AEOI and set-priority in the same cycle: OCW2 wins.
    ocw8(3'b100, 3'd0);
    both8(3'd1, 3'b110, 3'd3);
    vec_cnt++; if (a_lowest_prio !== 3'd3) begin err_cnt++; $display("FAIL aeoi_vs_ocw_prio got=%0d exp=3", a_lowest_prio); end
    ocw8(3'b010, 3'd6);
    vec_cnt++; if ({a_isr_out, a_lowest_prio} !== {8'h00, 3'd3}) begin err_cnt++; $display("FAIL nop got=%h/%0d exp=00/3", a_isr_out, a_lowest_prio); end
    a_aeoi_mode = 1'b0;
  endtask

  task automatic test_eoi_err();
    ocw8(3'b001, 3'd0);
    vec_cnt++; if (a_eoi_err !== 1'b1) begin err_cnt++; $display("FAIL ns_err_pulse got=%b exp=1", a_eoi_err); end
    vec_cnt++; if ({a_isr_out, a_lowest_prio} !== {8'h00, 3'd3}) begin err_cnt++; $display("FAIL ns_err_state got=%h/%0d exp=00/3", a_isr_out, a_lowest_prio); end
    step();
    vec_cnt++; if (a_eoi_err !== 1'b0) begin err_cnt++; $display("FAIL ns_err_width got=%b exp=0", a_eoi_err); end
    ocw8(3'b101, 3'd0);
    vec_cnt++; if ({a_eoi_err, a_lowest_prio} !== {1'b1, 3'd3}) begin err_cnt++; $display("FAIL rot_ns_err got=%b/%0d exp=1/3", a_eoi_err, a_lowest_prio); end
    ocw8(3'b011, 3'd3);
    vec_cnt++; if ({a_eoi_err, a_isr_out} !== {1'b0, 8'h00}) begin err_cnt++; $display("FAIL s_eoi_clear_bit got=%b/%h exp=0/00", a_eoi_err, a_isr_out); end
  endtask

  task automatic test_smm_collision();
    init8();
    ack8(3'd0);
    ack8(3'd4);
    vec_cnt++; if ({a_isr_out, a_top_idx} !== {8'h11, 3'd0}) begin err_cnt++; $display("FAIL smm_pre got=%h/%0d exp=11/0", a_isr_out, a_top_idx); end
    a_smm = 1'b1; a_imr = 8'h01;
    #1;
    vec_cnt++; if (a_top_idx !== 3'd4) begin err_cnt++; $display("FAIL smm_top got=%0d exp=4", a_top_idx); end
    vec_cnt++; if (a_isr_out !== 8'h11) begin err_cnt++; $display("FAIL smm_isr_kept got=%h exp=11", a_isr_out); end
    step();
    both8(3'd0, 3'b011, 3'd0);
    vec_cnt++; if (a_isr_out !== 8'h11) begin err_cnt++; $display("FAIL ack_wins got=%h exp=11", a_isr_out); end
    // Non-specific EOI clears the pre-update top (4, bit 0 masked) while ack sets 2.
    both8(3'd2, 3'b001, 3'd0);
    vec_cnt++; if (a_isr_out !== 8'h05) begin err_cnt++; $display("FAIL ns_with_ack got=%h exp=05", a_isr_out); end
    vec_cnt++; if (a_top_idx !== 3'd2) begin err_cnt++; $display("FAIL ns_with_ack_top got=%0d exp=2", a_top_idx); end
    a_smm = 1'b0; a_imr = 8'h00;
  endtask

  task automatic test_non_pow2();
    ack6(3'd7);
    vec_cnt++; if (b_isr_out !== 6'h00) begin err_cnt++; $display("FAIL oor_ack got=%h exp=00", b_isr_out); end
    ocw6(3'b110, 3'd2);
    ack6(3'd5);
    ocw6(3'b110, 3'd5);
    vec_cnt++; if ({b_lowest_prio, b_top_idx} !== {3'd5, 3'd5}) begin err_cnt++; $display("FAIL np2_top5 got=%0d/%0d exp=5/5", b_lowest_prio, b_top_idx); end
    ack6(3'd0);
    vec_cnt++; if ({b_isr_out, b_top_idx} !== {6'h21, 3'd0}) begin err_cnt++; $display("FAIL np2_wrap got=%h/%0d exp=21/0", b_isr_out, b_top_idx); end
    ocw6(3'b011, 3'd7);
    vec_cnt++; if (b_isr_out !== 6'h21) begin err_cnt++; $display("FAIL oor_s_eoi got=%h exp=21", b_isr_out); end
    ocw6(3'b110, 3'd6);
    vec_cnt++; if (b_lowest_prio !== 3'd5) begin err_cnt++; $display("FAIL oor_set_prio got=%0d exp=5", b_lowest_prio); end
  endtask

  initial begin
    reset = 1'b1;
    a_init_clear = 0; a_aeoi_mode = 0; a_ack_valid = 0; a_ack_idx = 0;
    a_ocw2_valid = 0; a_ocw2_cmd = 0; a_ocw2_level = 0; a_smm = 0; a_imr = 0;
    b_init_clear = 0; b_aeoi_mode = 0; b_ack_valid = 0; b_ack_idx = 0;
    b_ocw2_valid = 0; b_ocw2_cmd = 0; b_ocw2_level = 0; b_smm = 0; b_imr = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_ns_eoi();
    test_rotate();
    test_aeoi();
    test_eoi_err();
    test_smm_collision();
    test_non_pow2();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pic_isr_bank.md
Name: pic_isr_bank

Overview:
- Parametrised in-service register (ISR) for the PIC, generalised from 8 to NUM_IRQ levels.
- Fully synchronous:
  - sets the in-service bit on the interrupt acknowledge;
  - clears it on a specific or non-specific EOI, or automatically in AEOI mode;
  - maintains a rotating priority pointer.
- Reports the highest-priority in-service level to the control logic and the priority resolver.
- Sits between the priority resolver (acknowledge source) and the command decoder (OCW2 source).

Parameters:
- NUM_IRQ, 8, number of interrupt levels; legal range 2..32.
- IDX_W, $clog2(NUM_IRQ), width of a level index; derived, not to be overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- init_clear  in  1  one-cycle pulse from ICW1 decode; reinitialises the block
- aeoi_mode  in  1  1 = automatic EOI (ICW4 AEOI)
- ack_valid  in  1  one-cycle pulse at the end of the acknowledge that commits a level
- ack_idx  in  IDX_W  level being acknowledged
- ocw2_valid  in  1  one-cycle pulse: OCW2 command present
- ocw2_cmd  in  3  R,SL,EOI bits of OCW2
- ocw2_level  in  IDX_W  L field of OCW2
- smm  in  1  special mask mode enable
- imr  in  NUM_IRQ  interrupt mask register
- isr_out  out  NUM_IRQ  registered in-service vector
- top_valid  out  1  some unmasked in-service bit is set
- top_idx  out  IDX_W  highest-priority unmasked in-service level (0 when top_valid=0)
- lowest_prio  out  IDX_W  current lowest-priority level
- eoi_err  out  1  one-cycle pulse: non-specific EOI issued with no eligible bit

Behaviour:
- Reset values: isr_out=0, lowest_prio=NUM_IRQ-1, rotate_in_aeoi=0, eoi_err=0.
- init_clear has the same effect as reset.
- Priority order:
  - The highest-priority level is (lowest_prio+1) mod NUM_IRQ.
  - Priority decreases with increasing index, wrapping at NUM_IRQ.
- top_idx / top_valid:
  - Combinational, from the registered state.
  - Eligible vector = isr_out & ~(smm ? imr : 0).
  - Scanned from the highest-priority level with modulo-NUM_IRQ wrap.
- OCW2 commands (ocw2_cmd = R,SL,EOI):
  - 001 non-specific EOI: clear bit top_idx.
  - 011 specific EOI: clear bit ocw2_level.
  - 101 rotate on non-specific EOI: clear bit top_idx; lowest_prio <= top_idx.
  - 111 rotate on specific EOI: clear bit ocw2_level; lowest_prio <= ocw2_level.
  - 110 set priority: lowest_prio <= ocw2_level; isr_out unchanged.
  - 100 sets rotate_in_aeoi; 000 clears rotate_in_aeoi.
  - 010 is a no-op.
- Non-specific commands (001, 101) with top_valid=0:
  - isr_out and lowest_prio unchanged;
  - eoi_err=1 for one cycle.
- Specific EOI on a bit already clear: no change, no error.
- ack_valid, aeoi_mode=0: isr_out[ack_idx] <= 1.
- ack_valid, aeoi_mode=1:
  - The bit is never set (the level is done at the end of the acknowledge).
  - If rotate_in_aeoi=1, lowest_prio <= ack_idx.
- Latency: all state updates are visible one cycle after the qualifying pulse; no internal pipeline, no backpressure.
- Simultaneous ack_valid and ocw2_valid in one cycle:
  - The OCW2 clear target (including top_idx) is computed from the pre-update state.
  - Result = (isr_out & ~clear_mask) | set_mask. The ack set wins on the same bit.
  - If both request a lowest_prio update, the OCW2 rotation wins.
- Out-of-range index (ack_idx or ocw2_level >= NUM_IRQ, only possible for non-power-of-2 NUM_IRQ) is ignored: no state change.
- Precedence: reset > init_clear > (OCW2 + ack merged as above).
- smm affects only the selection of top_idx; masked in-service bits persist and remain in isr_out.

Decomposition:
- Shared package pic_pkg holds:
  - OCW2 command localparams: CMD_NS_EOI, CMD_S_EOI, CMD_ROT_NS_EOI, CMD_ROT_S_EOI, CMD_SET_PRIO, CMD_ROT_AEOI_SET, CMD_ROT_AEOI_CLR, CMD_NOP;
  - the IDX_W helper.
- One sub-module: pic_rot_prio_enc.
  - Parametrised NUM_IRQ, combinational.
  - Inputs: request vector, lowest_prio. Outputs: valid, idx.
  - Reused by the priority resolver.

Test Plan (NUM_IRQ=8 unless stated):
- After reset, ack idx 3 then ack idx 1 -> isr_out=0x0A, top_idx=1. Non-specific EOI -> isr_out=0x08, top_idx=3.
- Set priority L=4 (lowest_prio=4), ack idx 2 and 6 -> top_idx=6. Rotate on non-specific EOI -> isr_out=0x04, lowest_prio=6, top_idx=2.
- aeoi_mode=1, OCW2 100, ack idx 5 -> isr_out stays 0, lowest_prio=5. Then OCW2 000, ack idx 2 -> lowest_prio stays 5.
- isr_out=0x00, non-specific EOI -> eoi_err pulses 1 cycle, state unchanged. Specific EOI L=3 -> no error.
- isr_out=0x11, smm=1, imr=0x01 -> top_idx=4. Same cycle as ack idx 0 plus specific EOI L=0 -> isr_out=0x11 (ack wins).
- NUM_IRQ=6: ack idx 7 ignored. Ack idx 5, set priority L=5 -> top_idx=5, and with bits 0 and 5 set, top_idx=0 (wrap).
